collision_pair_gen: RTL and testbench

Parametrised successor to the equihash collision stage. It streams radix-sorted XOR records from memory through a credit-limited read port and groups consecutive records whose collision key matches into a bucket. For every new record in a bucket it emits one pair per older bucket member on a ready/valid output, carrying both record indices and the XOR of the two records. Unlike the previous stage, key width and position, bucket depth and read credits are parameters, the output tolerates backpressure, and bucket overflow is counted rather than silently lost.

---
 rtl/collision_pair_gen.sv | 190 +++++++++++++++++++
 tb/tb_collision_pair_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_pair_gen.sv
// Streams sorted XOR records through a credit-limited read port, buckets equal
// collision keys and emits (older, newer) record pairs on a ready/valid port.
module collision_pair_gen #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned KEY_W        = 20,
  parameter int unsigned KEY_LSB      = 0,
  parameter int unsigned BUCKET_DEPTH = 8,
  parameter int unsigned CREDITS      = 16
) (
  input  logic              eclk,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] cxor_base,
  input  logic [ADDR_W-1:0] cxor_end,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  output logic              rsend,
  input  logic              memc_cmd_full,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [ADDR_W-1:0] pair_idx_a,
  output logic [ADDR_W-1:0] pair_idx_b,
  output logic [DATA_W-1:0] pair_xor,
  output logic [ADDR_W-1:0] pair_count,
  output logic [15:0]       overflow_count
);
  localparam int unsigned FAW = $clog2(CREDITS);
  localparam int unsigned CW  = FAW + 1;
  localparam int unsigned BAW = $clog2(BUCKET_DEPTH);
  localparam int unsigned BW  = BAW + 1;
  localparam int unsigned PW  = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, end_q, pop_seq_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     credits_q, fifo_wp_q, fifo_rp_q;
  logic [DATA_W-1:0] fifo_mem [CREDITS];
  logic [KEY_W-1:0]  bkey_q;
  logic [BW-1:0]     bcnt_q, pj_q;
  logic [DATA_W-1:0] bdata [BUCKET_DEPTH];
  logic [ADDR_W-1:0] bidx  [BUCKET_DEPTH];
  logic [DATA_W-1:0] cur_q, px_q;
  logic [ADDR_W-1:0] pa_q, pb_q, pair_count_q;
  logic [15:0]       ovf_q;
  logic              pv_q, busy_q, done_q;

  logic              fifo_empty_c, push_c, pop_c, new_bucket_c, hs_c, last_c, append_c;
  logic              fetch_end_c, drain_end_c;
  logic [DATA_W-1:0] head_c;
  logic [KEY_W-1:0]  head_key_c;
  logic [ADDR_W-1:0] pop_idx_c;

  assign fifo_empty_c = (fifo_wp_q == fifo_rp_q);
  assign head_c       = fifo_mem[fifo_rp_q[FAW-1:0]];
  assign head_key_c   = head_c[KEY_LSB +: KEY_W];
  assign pop_idx_c    = base_q + pop_seq_q;
  // Returns that arrive while idle belong to an aborted pass and are dropped.
  assign push_c       = rvalid && (state_q != S_IDLE);
  assign pop_c        = !fifo_empty_c && !pv_q && (state_q == S_FETCH || state_q == S_DRAIN);
  assign new_bucket_c = pop_c && ((bcnt_q == '0) || (head_key_c != bkey_q));
  assign hs_c         = pv_q && pair_ready;
  assign last_c       = hs_c && (pj_q >= bcnt_q);
  assign append_c     = last_c && (bcnt_q < BW'(BUCKET_DEPTH));
  assign fetch_end_c  = rd_ptr_q > {1'b0, end_q};
  assign drain_end_c  = (credits_q == '0) && fifo_empty_c && !pv_q;

  // A credit spans issue to pop, so in-flight reads plus FIFO entries never exceed CREDITS.
  assign rsend = (state_q == S_FETCH) && !fetch_end_c && (credits_q < CW'(CREDITS)) && !memc_cmd_full;
  assign raddr = rsend ? rd_ptr_q[ADDR_W-1:0] : '0;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pair_valid     = pv_q;
  assign pair_idx_a     = pa_q;
  assign pair_idx_b     = pb_q;
  assign pair_xor       = px_q;
  assign pair_count     = pair_count_q;
  assign overflow_count = ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (fetch_end_c) state_d = S_DRAIN;
      S_DRAIN: if (drain_end_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Record storage needs no reset; bcnt_q and the FIFO pointers define validity.
  always_ff @(posedge eclk) begin
    if (push_c) fifo_mem[fifo_wp_q[FAW-1:0]] <= rdata;
    if (new_bucket_c) begin
      bdata[0] <= head_c;
      bidx[0]  <= pop_idx_c;
    end else if (append_c) begin
      bdata[bcnt_q[BAW-1:0]] <= cur_q;
      bidx[bcnt_q[BAW-1:0]]  <= pb_q;
    end
  end

  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      base_q       <= '0;
      end_q        <= '0;
      rd_ptr_q     <= '0;
      pop_seq_q    <= '0;
      credits_q    <= '0;
      fifo_wp_q    <= '0;
      fifo_rp_q    <= '0;
      bkey_q       <= '0;
      bcnt_q       <= '0;
      pj_q         <= '0;
      cur_q        <= '0;
      pv_q         <= 1'b0;
      pa_q         <= '0;
      pb_q         <= '0;
      px_q         <= '0;
      pair_count_q <= '0;
      ovf_q        <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        base_q       <= cxor_base;
        end_q        <= cxor_end;
        rd_ptr_q     <= {1'b0, cxor_base};
        pop_seq_q    <= '0;
        bcnt_q       <= '0;
        pair_count_q <= '0;
        ovf_q        <= '0;
      end else if (rsend) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      if (rsend && !pop_c)      credits_q <= credits_q + CW'(1);
      else if (!rsend && pop_c) credits_q <= credits_q - CW'(1);

      if (push_c) fifo_wp_q <= fifo_wp_q + CW'(1);

      // Pop: either open a fresh bucket or launch the pair engine at member 0.
      if (pop_c) begin
        fifo_rp_q <= fifo_rp_q + CW'(1);
        pop_seq_q <= pop_seq_q + ADDR_W'(1);
        if (new_bucket_c) begin
          bkey_q <= head_key_c;
          bcnt_q <= BW'(1);
        end else begin
          pv_q  <= 1'b1;
          pa_q  <= bidx[0];
          pb_q  <= pop_idx_c;
          px_q  <= bdata[0] ^ head_c;
          cur_q <= head_c;
          pj_q  <= BW'(1);
        end
      end

      if (hs_c) begin
        if (pair_count_q != '1) pair_count_q <= pair_count_q + ADDR_W'(1);
        if (!last_c) begin
          pa_q <= bidx[pj_q[BAW-1:0]];
          px_q <= bdata[pj_q[BAW-1:0]] ^ cur_q;
          pj_q <= pj_q + BW'(1);
        end else begin
          pv_q <= 1'b0;
          if (append_c)           bcnt_q <= bcnt_q + BW'(1);
          else if (ovf_q != '1)   ovf_q  <= ovf_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_pair_gen.sv
// Directed bench for collision_pair_gen: memory model, reference pair list and per-cycle compare.
module tb_collision_pair_gen;
  logic         eclk = 1'b0, rstb = 1'b0, start = 1'b0;
  logic [31:0]  cxor_base = '0, cxor_end = '0;
  logic         busy, done, rsend, pair_valid;
  logic [31:0]  raddr, pair_idx_a, pair_idx_b, pair_count;
  logic [255:0] pair_xor, rdata = '0;
  logic [15:0]  overflow_count;
  logic         memc_cmd_full = 1'b0, rvalid = 1'b0, pair_ready = 1'b1;

  collision_pair_gen dut (
    .eclk(eclk), .rstb(rstb), .start(start), .cxor_base(cxor_base), .cxor_end(cxor_end),
    .busy(busy), .done(done), .raddr(raddr), .rsend(rsend), .memc_cmd_full(memc_cmd_full),
    .rdata(rdata), .rvalid(rvalid), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_idx_a(pair_idx_a), .pair_idx_b(pair_idx_b), .pair_xor(pair_xor),
    .pair_count(pair_count), .overflow_count(overflow_count)
  );

  always #5 eclk = ~eclk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int key_tab [0:127];
  logic [31:0]  base_cur = '0, exp_raddr = '0;
  logic [31:0]  pend_a[$];
  int           pend_t[$];
  logic [31:0]  exp_a[$], exp_b[$];
  logic [255:0] exp_x[$];
  int  exp_total = 0, exp_ovf = 0;
  bit  ret_en = 1'b1, rdy_mode = 1'b0, full_mode = 1'b0, gap_mode = 1'b0, rdy_tog = 1'b0;
  int  done_cnt = 0, rsend_cnt = 0, hs_cnt = 0, rv_n = 0;
  int  cyc_rv2 = 0, cyc_pv1 = 0, start_cyc = 0, done_cyc = 0, last_hs_cyc = 0;
  bit  pv_seen = 1'b0, start_seen = 1'b0, stall_prev = 1'b0;
  logic [31:0]  sa = '0, sb = '0;
  logic [255:0] sx = '0;

  function automatic logic [255:0] rec(input int off);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'((off + 1) * (w + 7) * 40503) ^ 32'(w * 4369);
    r[19:0] = 20'(key_tab[off]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: walk the records in order, keeping the run of equal keys (capped at 8 members).
  task automatic prep(input int n, input logic [31:0] base);
    int run[$];
    exp_a.delete(); exp_b.delete(); exp_x.delete();
    exp_ovf = 0;
    for (int i = 0; i < n; i++) begin
      if (run.size() == 0 || key_tab[i] != key_tab[run[0]]) begin
        run.delete();
        run.push_back(i);
      end else begin
        foreach (run[j]) begin
          exp_a.push_back(base + 32'(run[j]));
          exp_b.push_back(base + 32'(i));
          exp_x.push_back(rec(run[j]) ^ rec(i));
        end
        if (run.size() < 8) run.push_back(i);
        else exp_ovf++;
      end
    end
    exp_total = exp_a.size();
    base_cur = base; exp_raddr = base;
    done_cnt = 0; rsend_cnt = 0; hs_cnt = 0; rv_n = 0; pv_seen = 0; start_seen = 0;
    cxor_base = base; cxor_end = base + 32'(n) - 32'd1;
  endtask

  task automatic go();
    @(posedge eclk); #1 start = 1'b1;
    @(posedge eclk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin @(negedge eclk); #1; end
    chk("done_before_timeout", done_cnt != 0, 1'b1);
    repeat (3) @(negedge eclk);
    #1;
  endtask

  task automatic end_checks(input string nm);
    chk({nm, "_pair_count"}, pair_count, 32'(exp_total));
    chk({nm, "_overflow"}, overflow_count, 16'(exp_ovf));
    chk({nm, "_handshakes"}, hs_cnt, exp_total);
    chk({nm, "_pairs_left"}, exp_a.size(), 0);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_busy_low"}, busy, 1'b0);
    if (exp_total > 0) chk({nm, "_done_after_last_pair"}, done_cyc > last_hs_cyc, 1'b1);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_rsend"}, rsend, 1'b0);
    chk({nm, "_pair_valid"}, pair_valid, 1'b0);
    chk({nm, "_raddr"}, raddr, 32'd0);
    chk({nm, "_idx_a"}, pair_idx_a, 32'd0);
    chk({nm, "_idx_b"}, pair_idx_b, 32'd0);
    chk({nm, "_xor"}, pair_xor, 256'd0);
    chk({nm, "_pair_count"}, pair_count, 32'd0);
    chk({nm, "_overflow"}, overflow_count, 16'd0);
  endtask

  // Inputs change 1 time unit after the rising edge.
  always @(posedge eclk) begin
    #1;
    rdy_tog = !rdy_tog;
    pair_ready = rdy_mode ? rdy_tog : 1'b1;
    memc_cmd_full = full_mode ? ($urandom_range(2) == 0) : 1'b0;
    if (ret_en && pend_a.size() > 0 && pend_t[0] <= cyc && (!gap_mode || $urandom_range(1) == 1)) begin
      rvalid = 1'b1;
      rdata  = rec(int'(pend_a[0] - base_cur));
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  // Outputs are sampled on the falling edge.
  always @(negedge eclk) begin
    cyc++;
    if (rsend) begin
      rsend_cnt++;
      chk("rsend_while_full", memc_cmd_full, 1'b0);
      chk("raddr", raddr, exp_raddr);
      exp_raddr++;
      pend_a.push_back(raddr);
      pend_t.push_back(cyc + 2);
    end
    if (rvalid && pend_a.size() > 0) begin
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
      rv_n++;
      if (rv_n == 2) cyc_rv2 = cyc;
    end
    if (busy) chk("inflight_le_16", pend_a.size() <= 16, 1'b1);
    if (rstb && stall_prev) begin
      chk("stall_valid_held", pair_valid, 1'b1);
      chk("stall_idx_a", pair_idx_a, sa);
      chk("stall_idx_b", pair_idx_b, sb);
      chk("stall_xor", pair_xor, sx);
    end
    if (pair_valid && !pv_seen) begin pv_seen = 1'b1; cyc_pv1 = cyc; end
    if (pair_valid && pair_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_a.size() == 0) chk("extra_pair", hs_cnt, exp_total);
      else begin
        chk("pair_idx_a", pair_idx_a, exp_a.pop_front());
        chk("pair_idx_b", pair_idx_b, exp_b.pop_front());
        chk("pair_xor", pair_xor, exp_x.pop_front());
      end
    end
    stall_prev = rstb && pair_valid && !pair_ready;
    sa = pair_idx_a; sb = pair_idx_b; sx = pair_xor;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (start && !busy && !start_seen) begin start_seen = 1'b1; start_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge eclk);
    reset_vals("reset");
    @(posedge eclk); #1 rstb = 1'b1;

    // Keys 5,5,5,9
    key_tab[0] = 5; key_tab[1] = 5; key_tab[2] = 5; key_tab[3] = 9;
    prep(4, 32'h100);
    chk("model_t1_npairs", exp_total, 3);
    chk("model_t1_a0", exp_a[0], 32'h100); chk("model_t1_b0", exp_b[0], 32'h101);
    chk("model_t1_a1", exp_a[1], 32'h100); chk("model_t1_b1", exp_b[1], 32'h102);
    chk("model_t1_a2", exp_a[2], 32'h101); chk("model_t1_b2", exp_b[2], 32'h102);
    go(); wait_done(); end_checks("t1");
    chk("t1_first_pair_latency", cyc_pv1 - cyc_rv2, 2);

    // Ten equal keys: two records overflow the 8-deep bucket
    for (int i = 0; i < 10; i++) key_tab[i] = 7;
    prep(10, 32'h200);
    chk("model_t2_npairs", exp_total, 44);
    chk("model_t2_ovf", exp_ovf, 2);
    go(); wait_done(); end_checks("t2");

    // Backpressure, random command-queue full and return gaps
    for (int i = 0; i < 24; i++)
      key_tab[i] = (i < 4) ? 3 : (i < 6) ? 8 : (i < 17) ? 6 : (i == 17) ? 1 : (i < 23) ? 2 : 9;
    prep(24, 32'h7F0);
    chk("model_t3_npairs", exp_total, 69);
    chk("model_t3_ovf", exp_ovf, 3);
    rdy_mode = 1'b1; full_mode = 1'b1; gap_mode = 1'b1;
    go(); wait_done(); end_checks("t3");
    rdy_mode = 1'b0; full_mode = 1'b0; gap_mode = 1'b0;

    // Empty range; a second start lands on the done cycle
    prep(0, 32'h50);
    go();
    @(posedge eclk); #1;
    @(posedge eclk); #1 start = 1'b1;
    @(posedge eclk); #1 start = 1'b0;
    wait_done(); end_checks("t4");
    chk("t4_rsend_count", rsend_cnt, 0);
    chk("t4_done_latency", done_cyc - start_cyc, 3);
    repeat (6) @(negedge eclk);
    #1;
    chk("t4_start_on_done_ignored_busy", busy, 1'b0);
    chk("t4_start_on_done_ignored_done", done_cnt, 1);

    // Reset with five reads outstanding, late returns while idle, then a clean pass
    for (int i = 0; i < 32; i++) key_tab[i] = i / 2;
    prep(32, 32'h300);
    ret_en = 1'b0;
    go();
    for (int i = 0; i < 100 && pend_a.size() < 5; i++) begin @(negedge eclk); #1; end
    @(posedge eclk); #1 rstb = 1'b0;
    exp_a.delete(); exp_b.delete(); exp_x.delete(); exp_total = 0;
    chk("t5_inflight_at_reset", pend_a.size(), 5);
    @(negedge eclk);
    reset_vals("t5_reset");
    @(posedge eclk); #1 rstb = 1'b1; ret_en = 1'b1; done_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 50 && pend_a.size() > 0; i++) begin @(negedge eclk); #1; end
    repeat (4) @(negedge eclk);
    #1;
    chk("t5_late_returns_drained", pend_a.size(), 0);
    chk("t5_no_pairs_after_abort", hs_cnt, 0);
    chk("t5_no_done_after_abort", done_cnt, 0);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_pair_count", pair_count, 32'd0);
    key_tab[0] = 5; key_tab[1] = 5; key_tab[2] = 5; key_tab[3] = 9;
    prep(4, 32'h400);
    go(); wait_done(); end_checks("t5_clean");

    // 64 distinct keys
    for (int i = 0; i < 64; i++) key_tab[i] = i * 3 + 1;
    prep(64, 32'h1000);
    chk("model_t6_npairs", exp_total, 0);
    go(); wait_done(); end_checks("t6");
    chk("t6_rsend_count", rsend_cnt, 64);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
